// File: rtl/multdiv_sequencer.sv
// Issue/sequence controller between the pipeline and the shared multiplier/divider.
// Latches one request, pulses the unit's start, stalls, then writes back once (or aborts).
module multdiv_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        mult_start,
    output logic        div_start,
    output logic        md_interrupt,
    input  logic [31:0] mult_result,
    input  logic        mult_ready,
    input  logic        mult_exception,
    input  logic [31:0] div_result,
    input  logic        div_ready,
    input  logic        div_exception,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    typedef struct packed {
        logic        isDiv;
        logic [4:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
    } mdReq_t;

    state_t           state, nextState;
    mdReq_t           req;
    logic [CNT_W-1:0] cnt;

    logic        issueAny, accept, cntHit;
    logic        selReady, selExc;
    logic [31:0] selResult;

    assign issueAny = issue_mult | issue_div;
    assign accept   = (state == IDLE) && issueAny && !flush;
    assign cntHit   = (cnt == CNT_W'(TIMEOUT));

    // Only the unit that was started is listened to.
    assign selReady  = req.isDiv ? div_ready     : mult_ready;
    assign selExc    = req.isDiv ? div_exception : mult_exception;
    assign selResult = req.isDiv ? div_result    : mult_result;

    assign md_opA = req.a;
    assign md_opB = req.b;

    always_comb begin
        nextState    = state;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        md_interrupt = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                stall = 1'b1;
                if (flush) begin
                    md_interrupt = 1'b1;
                    nextState    = IDLE;
                end else begin
                    mult_start = !req.isDiv;
                    div_start  = req.isDiv;
                    nextState  = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    md_interrupt = 1'b1;
                    nextState    = IDLE;
                end else if (selReady) begin
                    nextState = DONE;
                end else if (cntHit) begin
                    timeout      = 1'b1;
                    md_interrupt = 1'b1;
                    nextState    = DONE;
                end
            end
            DONE: begin
                wb_valid  = !flush;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Held reset parks both units in clear and silences everything else.
        if (!reset) begin
            nextState    = IDLE;
            mult_start   = 1'b0;
            div_start    = 1'b0;
            stall        = 1'b0;
            wb_valid     = 1'b0;
            timeout      = 1'b0;
            md_interrupt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            req          <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= '0;
        end else begin
            state <= nextState;
            if (accept)
                req <= '{isDiv: !issue_mult, dst: rd, a: opA, b: opB};
            if (state == LAUNCH)
                cnt <= '0;
            else if (state == WAIT && !cntHit)
                cnt <= cnt + 1'b1;
            // Capture on the completing WAIT edge; a flush in that cycle wins.
            if (state == WAIT && !flush) begin
                if (selReady) begin
                    wb_rd        <= req.dst;
                    wb_data      <= selResult;
                    wb_exception <= selExc;
                end else if (cntHit) begin
                    wb_rd        <= req.dst;
                    wb_data      <= '0;
                    wb_exception <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with simple fixed-latency mult/div unit models.
module tb_multdiv_sequencer;

    localparam int DIV_LAT = 33;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_mult, issue_div, flush;
    logic [31:0] opA, opB;
    logic [4:0]  rd;
    logic [31:0] md_opA, md_opB;
    logic        mult_start, div_start, md_interrupt;
    logic [31:0] mult_result, div_result;
    logic        mult_ready, div_ready, mult_exception, div_exception;
    logic        stall, wb_valid, wb_exception, timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        mulRdy = 1'b0, divRdy = 1'b0;
    logic        staleMult = 1'b0, staleDiv = 1'b0, holdReady = 1'b0;
    int          mulCnt = 0, divCnt = 0;
    int          testCnt = 0, errCnt = 0;

    assign mult_ready = mulRdy | staleMult;
    assign div_ready  = divRdy | staleDiv;

    always #5 clk = ~clk;

    multdiv_sequencer dut (
        .clk(clk), .reset(reset),
        .issue_mult(issue_mult), .issue_div(issue_div),
        .opA(opA), .opB(opB), .rd(rd), .flush(flush),
        .md_opA(md_opA), .md_opB(md_opB),
        .mult_start(mult_start), .div_start(div_start), .md_interrupt(md_interrupt),
        .mult_result(mult_result), .mult_ready(mult_ready), .mult_exception(mult_exception),
        .div_result(div_result), .div_ready(div_ready), .div_exception(div_exception),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exception(wb_exception), .timeout(timeout)
    );

    function automatic logic [32:0] mulModel(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    endfunction

    function automatic logic [32:0] divModel(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    // Unit models: ready is a single-cycle pulse LAT edges after the start edge.
    always @(posedge clk) begin
        mulRdy <= 1'b0;
        divRdy <= 1'b0;
        if (md_interrupt) begin
            mulCnt <= 0;
            divCnt <= 0;
        end else begin
            if (mult_start) mulCnt <= MUL_LAT;
            else if (mulCnt != 0) begin
                mulCnt <= mulCnt - 1;
                if (mulCnt == 1 && !holdReady) begin
                    mulRdy <= 1'b1;
                    {mult_exception, mult_result} <= mulModel(md_opA, md_opB);
                end
            end
            if (div_start) divCnt <= DIV_LAT;
            else if (divCnt != 0) begin
                divCnt <= divCnt - 1;
                if (divCnt == 1 && !holdReady) begin
                    divRdy <= 1'b1;
                    {div_exception, div_result} <= divModel(md_opA, md_opB);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an issue for one cycle; returns at mid-cycle of LAUNCH.
    task automatic issueOp(input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] r);
        issue_mult = m; issue_div = d; opA = a; opB = b; rd = r;
        @(negedge clk);
        check("issue_stall", stall, 1);
        step();
        issue_mult = 0; issue_div = 0; opA = 32'hDEAD_BEEF; opB = 32'hDEAD_BEEF; rd = 5'd31;
        @(negedge clk);
    endtask

    // Called at posedge+1 of WAIT cycle 0; returns at mid-cycle of DONE.
    task automatic waitDone(input int maxCyc, output int cyc);
        cyc = -1;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                cyc = i;
                return;
            end
            step();
        end
        check("wb_wait_expired", 0, 1);
    endtask

    initial begin
        int cyc, seen;
        bit hit;
        reset = 0; issue_mult = 0; issue_div = 0; flush = 0;
        opA = 0; opB = 0; rd = 0;
        step(); step();
        @(negedge clk);
        check("rst_int", md_interrupt, 1);
        check("rst_stall", stall, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_start", {mult_start, div_start}, 0);
        check("rst_opA", md_opA, 0);
        check("rst_wbdata", wb_data, 0);
        step();
        reset = 1;
        step();
        @(negedge clk);
        check("idle_int", md_interrupt, 0);
        step();

        // 1: div 100 / -7, other unit's ready and a stray issue during WAIT ignored
        issueOp(0, 1, 32'd100, -32'sd7, 5'd9);
        check("t1_start", {mult_start, div_start}, 2'b01);
        step();
        staleMult = 1; issue_mult = 1; opA = 32'h1234;
        @(negedge clk);
        check("t1_opA_held", md_opA, 32'd100);
        check("t1_wait_stall", stall, 1);
        step();
        issue_mult = 0;
        waitDone(80, cyc);
        staleMult = 0;
        check("t1_latency", cyc, DIV_LAT);
        check("t1_data", wb_data, 32'hFFFF_FFF2);
        check("t1_rd", wb_rd, 9);
        check("t1_exc", wb_exception, 0);
        check("t1_done_stall", stall, 0);
        step();
        @(negedge clk);
        check("t1_wb_once", wb_valid, 0);
        check("t1_wb_hold", wb_data, 32'hFFFF_FFF2);
        step();

        // 2: mult -3 * 5, stale ready in LAUNCH and div ready during WAIT ignored
        issueOp(1, 0, -32'sd3, 32'd5, 5'd3);
        check("t2_start", {mult_start, div_start}, 2'b10);
        staleMult = 1;
        step();
        staleMult = 0; staleDiv = 1;
        waitDone(20, cyc);
        staleDiv = 0;
        check("t2_latency", cyc, MUL_LAT + 1);
        check("t2_data", wb_data, 32'hFFFF_FFF1);
        check("t2_exc", wb_exception, 0);
        check("t2_rd", wb_rd, 3);
        step(); step();

        // 3: divide by zero
        issueOp(0, 1, 32'd7, 32'd0, 5'd12);
        step();
        waitDone(80, cyc);
        check("t3_wbv", wb_valid, 1);
        check("t3_exc", wb_exception, 1);
        check("t3_rd", wb_rd, 12);
        step(); step();

        // 4: flush 10 cycles into a div, then a normal mult
        issueOp(0, 1, 32'd50, 32'd5, 5'd20);
        repeat (11) step();
        flush = 1;
        @(negedge clk);
        check("t4_int", md_interrupt, 1);
        step();
        flush = 0;
        @(negedge clk);
        check("t4_int_once", md_interrupt, 0);
        check("t4_idle_stall", stall, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_valid) seen++;
            step();
        end
        check("t4_no_wb", seen, 0);
        issueOp(1, 0, 32'd6, 32'd7, 5'd5);
        step();
        waitDone(20, cyc);
        check("t4_mul_data", wb_data, 32'd42);
        check("t4_mul_rd", wb_rd, 5);
        step(); step();

        // flush in IDLE drops a concurrent issue
        issue_mult = 1; flush = 1; opA = 32'd99;
        @(negedge clk);
        check("fi_stall", stall, 0);
        step();
        issue_mult = 0; flush = 0;
        @(negedge clk);
        check("fi_no_start", mult_start, 0);
        check("fi_opA", md_opA, 32'd6);
        step();

        // flush in DONE suppresses the writeback strobe
        issueOp(1, 0, 32'd2, 32'd3, 5'd4);
        step();
        repeat (MUL_LAT + 1) step();
        flush = 1;
        @(negedge clk);
        check("fd_data", wb_data, 32'd6);
        check("fd_wbv", wb_valid, 0);
        step();
        flush = 0;
        @(negedge clk);
        check("fd_wbv_after", wb_valid, 0);
        step();

        // 5: watchdog
        holdReady = 1;
        issueOp(0, 1, 32'd1, 32'd1, 5'd7);
        step();
        hit = 0; cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (timeout) begin
                hit = 1; cyc = i;
                break;
            end
            step();
        end
        check("t5_tmo_seen", hit, 1);
        check("t5_tmo_cycle", cyc, 64);
        check("t5_tmo_int", md_interrupt, 1);
        step();
        @(negedge clk);
        check("t5_wbv", wb_valid, 1);
        check("t5_exc", wb_exception, 1);
        check("t5_data", wb_data, 0);
        check("t5_rd", wb_rd, 7);
        check("t5_tmo_once", timeout, 0);
        holdReady = 0;
        step(); step();

        // 6: both issues -> mult wins; reset mid-WAIT discards the op
        issueOp(1, 1, 32'd4, 32'd4, 5'd8);
        check("t6_start", {mult_start, div_start}, 2'b10);
        step(); step();
        reset = 0;
        @(negedge clk);
        check("t6_rst_int", md_interrupt, 1);
        check("t6_rst_stall", stall, 0);
        step();
        @(negedge clk);
        check("t6_rst_int2", md_interrupt, 1);
        check("t6_rst_stall2", stall, 0);
        check("t6_rst_opA", md_opA, 0);
        step();
        reset = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (wb_valid) seen++;
            step();
        end
        check("t6_no_wb", seen, 0);
        check("t6_int_clr", md_interrupt, 0);

        $display("[TB] %0d tests run, %0d failed", testCnt, errCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running exp finished");
        $fatal(1);
    end

endmodule
